// File: rtl/intellight_pkg.sv
// intellight_pkg: shared constants and scan FSM encoding for the Intellight Q-value selection path
package intellight_pkg;
    localparam int N_ACTION  = 4;
    localparam int ACT_WIDTH = 2;
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} scan_state_e;
endpackage

// File: rtl/qmax_scan_controller.sv
// qmax_scan_controller: walks the 4:1 Q-value mux, tracks the signed running maximum
// and applies an epsilon-greedy override to the chosen action
module qmax_scan_controller
    import intellight_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         explore,
    input  logic [ACT_WIDTH-1:0]         rand_act,
    input  logic signed [DATA_WIDTH-1:0] q_in,
    output logic [ACT_WIDTH-1:0]         sel,
    output logic                         busy,
    output logic                         done,
    output logic signed [DATA_WIDTH-1:0] max_q,
    output logic [ACT_WIDTH-1:0]         max_act,
    output logic [ACT_WIDTH-1:0]         act
);
    scan_state_e                  state_q, state_d;
    logic [ACT_WIDTH-1:0]         sel_q, sel_d;
    logic                         explore_q, explore_d;
    logic [ACT_WIDTH-1:0]         rand_q, rand_d;
    logic signed [DATA_WIDTH-1:0] max_q_q, max_q_d;
    logic [ACT_WIDTH-1:0]         max_act_q, max_act_d;
    logic [ACT_WIDTH-1:0]         act_q, act_d;
    logic                         load, last;

    // strict compare keeps the lowest index among equal maxima
    assign load = (sel_q == '0) || (q_in > max_q_q);
    assign last = sel_q == ACT_WIDTH'(N_ACTION - 1);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        explore_d = explore_q;
        rand_d    = rand_q;
        max_q_d   = max_q_q;
        max_act_d = max_act_q;
        act_d     = act_q;
        case (state_q)
            IDLE: if (start) begin
                state_d   = SCAN;
                sel_d     = '0;
                explore_d = explore;
                rand_d    = rand_act;
            end
            SCAN: begin
                if (load) begin
                    max_q_d   = q_in;
                    max_act_d = sel_q;
                end
                if (last) begin
                    state_d = DONE;
                    sel_d   = '0;
                    act_d   = explore_q ? rand_q : max_act_d;
                end else begin
                    sel_d = sel_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            explore_q <= 1'b0;
            rand_q    <= '0;
            max_q_q   <= '0;
            max_act_q <= '0;
            act_q     <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            explore_q <= explore_d;
            rand_q    <= rand_d;
            max_q_q   <= max_q_d;
            max_act_q <= max_act_d;
            act_q     <= act_d;
        end
    end

    assign sel     = sel_q;
    assign busy    = state_q != IDLE;
    assign done    = state_q == DONE;
    assign max_q   = max_q_q;
    assign max_act = max_act_q;
    assign act     = act_q;
endmodule

// File: tb/tb_qmax_scan_controller.sv
// tb_qmax_scan_controller: random and directed scans checked every cycle against a scan-level model
module tb_qmax_scan_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic explore = 1'b0;
    logic [1:0] rand_act = '0;
    logic signed [15:0] qv [4];
    logic signed [15:0] q_in;
    logic [1:0] sel, max_act, act;
    logic busy, done;
    logic signed [15:0] max_q;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign q_in = qv[sel];

    qmax_scan_controller #(.DATA_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .explore(explore), .rand_act(rand_act),
        .q_in(q_in), .sel(sel), .busy(busy), .done(done), .max_q(max_q),
        .max_act(max_act), .act(act)
    );

    task automatic check(input string n, input int a, input int e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", n, a, e);
        end
    endtask

    // phase 0 = idle, 1..4 = scanning index phase-1, 5 = result cycle
    int phase = 0;
    int s [4];
    int m_q = 0, m_a = 0, m_act = 0, m_rand = 0;
    bit m_exp = 0;

    always @(posedge clk or negedge rst_n) begin
        int mx;
        if (!rst_n) begin
            phase = 0;
            m_q = 0;
            m_a = 0;
            m_act = 0;
            m_exp = 0;
            m_rand = 0;
        end else if (phase == 0) begin
            if (start) begin
                phase = 1;
                m_exp = explore;
                m_rand = rand_act;
            end
        end else if (phase <= 4) begin
            s[phase-1] = qv[phase-1];
            if (phase == 4) begin
                mx = s[0];
                for (int i = 1; i < 4; i++) if (s[i] > mx) mx = s[i];
                m_a = 0;
                for (int i = 3; i >= 0; i--) if (s[i] == mx) m_a = i;
                m_q = mx;
                m_act = m_exp ? m_rand : m_a;
            end
            phase++;
        end else begin
            phase = 0;
        end
    end

    always @(negedge clk) begin
        check("busy", busy, phase != 0);
        check("done", done, phase == 5);
        check("sel", sel, (phase >= 1 && phase <= 4) ? phase - 1 : 0);
        check("act", act, m_act);
        if (phase == 0 || phase == 5) begin
            check("max_q", max_q, m_q);
            check("max_act", max_act, m_a);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    task automatic run_scan(input int q0, input int q1, input int q2, input int q3,
                            input bit ex, input logic [1:0] ra,
                            input int eq, input int ea, input int eact);
        int n;
        wait_idle();
        qv[0] = 16'(q0);
        qv[1] = 16'(q1);
        qv[2] = 16'(q2);
        qv[3] = 16'(q3);
        explore = ex;
        rand_act = ra;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("lit_latency", n, 5);
        check("lit_max_q", max_q, eq);
        check("lit_max_act", max_act, ea);
        check("lit_act", act, eact);
    endtask

    initial begin
        int nd, k, d[$];
        for (int i = 0; i < 4; i++) qv[i] = '0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sel", sel, 0);
        check("rst_max_q", max_q, 0);
        check("rst_act", act, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_scan(5, -3, 12, 7, 0, 2'd1, 12, 2, 2);
        run_scan(-8, -2, -2, -20, 0, 2'd3, -2, 1, 1);
        run_scan(32767, -32768, 0, 1, 1, 2'd3, 32767, 0, 3);

        wait_idle();
        qv[0] = 16'sd1; qv[1] = 16'sd9; qv[2] = 16'sd3; qv[3] = 16'sd9;
        explore = 1'b0;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            start = (i == 0 || i == 2 || i == 3);
            @(negedge clk);
            if (done) nd++;
        end
        start = 1'b0;
        check("lit_one_done", nd, 1);
        check("lit_ignored_max_act", max_act, 1);

        wait_idle();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (sel != 2 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("lit_reached_sel2", sel, 2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sel", sel, 0);
        check("mid_rst_max_q", max_q, 0);
        check("mid_rst_max_act", max_act, 0);
        check("mid_rst_act", act, 0);
        @(negedge clk);
        check("mid_rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_scan(-1, 4, 4, 3, 1, 2'd2, 4, 1, 2);

        wait_idle();
        qv[0] = -16'sd5; qv[1] = -16'sd6; qv[2] = -16'sd7; qv[3] = -16'sd4;
        explore = 1'b0;
        start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) d.push_back(i);
        end
        start = 1'b0;
        check("lit_held_count", d.size(), 3);
        if (d.size() == 3) begin
            check("lit_held_first", d[0], 5);
            check("lit_held_gap1", d[1] - d[0], 6);
            check("lit_held_gap2", d[2] - d[1], 6);
        end
        wait_idle();
        check("lit_held_max_q", max_q, -4);

        for (int c = 0; c < 1500; c++) begin
            bit narrow;
            narrow = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < 4; i++)
                qv[i] = narrow ? 16'($signed($urandom_range(0, 4)) - 2) : 16'($urandom);
            start = ($urandom_range(0, 2) == 0);
            explore = $urandom_range(0, 1);
            rand_act = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/qmax_scan_controller.md
# qmax_scan_controller

Sequencer for the Q-value selection path of the Intellight accelerator. It steps a 4:1 action multiplexer, with select width 2, through all four Q-values of the current state, one per cycle. It tracks the running signed maximum and its action index, and applies an epsilon-greedy exploration override to the chosen action. It sits between the Q-table read port / `mux4to1` instance and the action-selection and Q-update logic.

## Interface
Parameters:
- `DATA_WIDTH`, default 16: Q-value width, two's-complement signed.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a scan; accepted only in IDLE.
- `explore`  in  1  sampled with accepted `start`; 1 selects the exploration action.
- `rand_act`  in  2  random action index; sampled with accepted `start`.
- `q_in`  in  DATA_WIDTH  mux output, i.e. the Q-value selected by `sel`. Combinational, same cycle as `sel`.
- `sel`  out  2  select line driven to the 4:1 mux.
- `busy`  out  1  high while not in IDLE.
- `done`  out  1  one-cycle pulse when results are valid.
- `max_q`  out  DATA_WIDTH  maximum Q-value found; signed.
- `max_act`  out  2  index of `max_q`.
- `act`  out  2  chosen action: `rand_act` if exploring, else `max_act`.

## Operation
- FSM states: IDLE, SCAN, DONE.
  - IDLE → SCAN on `start`=1. Latch `explore` and `rand_act`. Set `sel`=0.
  - SCAN: each cycle sample `q_in` at index `sel`.
    - If `sel`=0, load unconditionally: `max_q`←`q_in`, `max_act`←0.
    - Otherwise, if `q_in` > `max_q` (signed, strict), load `max_q`←`q_in` and `max_act`←`sel`.
    - If `sel`=3, go to DONE. Otherwise `sel`←`sel`+1.
  - DONE → IDLE unconditionally. `done`=1 for this cycle only. `act` is updated here.
- Tie-break: strict compare, so the lowest index wins among equal maxima.
- Compare is full-width signed. There is no saturation and no arithmetic beyond the compare.
- `start` while `busy`=1 is ignored. It is neither queued nor allowed to restart the scan.
- `max_q`, `max_act` and `act` hold their last values until the next scan overwrites them. Intermediate `max_q`/`max_act` values are visible during SCAN and are valid only at `done`.
- `sel` returns to 0 in DONE and IDLE.
- Reset, asynchronous and allowed at any time including mid-scan:
  - state→IDLE.
  - `sel`, `busy`, `done`, `max_q`, `max_act`, `act` → 0.
  - Latched `explore` and `rand_act` → 0.
  - A partial scan is discarded and no `done` is issued.

## Timing
- `start` accepted at edge T → SCAN for edges T+1..T+4, with `sel` = 0,1,2,3 in those cycles.
- DONE in the cycle after edge T+4: `done` is high, and `max_q`/`max_act`/`act` are valid from that cycle onward.
- Total: 5 cycles from the `start` edge to the `done` pulse.
- `busy` rises the cycle after `start` is accepted and falls when IDLE is re-entered, the cycle after `done`.
- Back-to-back: `start` held high is accepted again in IDLE. Maximum throughput is one scan per 6 cycles.
- `q_in` must be stable within the cycle `sel` is presented. The block adds no mux pipeline stage.

## Structure
- Shared package `intellight_pkg`:
  - FSM state encoding, 2 bits: IDLE=0, SCAN=1, DONE=2.
  - `N_ACTION`=4 and `ACT_WIDTH`=2 constants.
- Single module with no sub-modules. The `mux4to1` is instantiated by the parent, with `sel`/`q_in` wired across.

## Test plan
- Q = {5, -3, 12, 7}, `explore`=0 → `done` 5 cycles after `start`; `max_q`=12, `max_act`=2, `act`=2; `sel` sequence 0,1,2,3.
- All negative, Q = {-8, -2, -2, -20} → `max_q`=-2, `max_act`=1 (lowest index on tie, signed compare).
- Q = {0x7FFF, 0x8000, 0, 1}, `explore`=1, `rand_act`=3 → `max_q`=0x7FFF, `max_act`=0, `act`=3.
- `start` pulsed again at cycles 2 and 3 of a scan → ignored; exactly one `done` pulse; next scan starts only after IDLE is re-entered.
- `rst_n` asserted at `sel`=2 mid-scan → all outputs 0 immediately, no `done`. A new `start` after release gives a correct full 5-cycle scan.
- `start` held high for 20 cycles → `done` pulses exactly every 6 cycles; `busy` is low for one cycle between scans.
